video_ula: RTL and testbench



---
 rtl/video_ula_if.sv | 38 +++
 rtl/video_ula.sv | 120 ++++++++++++
 tb/tb_video_ula.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_ula_if.sv
// video_ula_if
//
// Groups the non-clock signals of the video ULA into a single bundle.
// The master side (CPU bus, CRTC and framestore) drives the register-write
// signals and the per-character inputs. The slave side (the ULA) returns
// the character clock and the pixel colour.
//
// Signals:
//   wr_en       single-cycle register write strobe
//   RS          register select: 0 = control, 1 = palette
//   wr_data     register write data
//   vram_data   framestore byte for the current character
//   display_en  CRTC display enable
//   cursor      CRTC cursor flag
//   char_clk    character clock back to the CRTC
//   red/green/blue  pixel output
interface video_ula_if;
    logic       wr_en;
    logic       RS;
    logic [7:0] wr_data;
    logic [7:0] vram_data;
    logic       display_en;
    logic       cursor;
    logic       char_clk;
    logic       red;
    logic       green;
    logic       blue;

    modport master (
        output wr_en, RS, wr_data, vram_data, display_en, cursor,
        input  char_clk, red, green, blue
    );

    modport slave (
        input  wr_en, RS, wr_data, vram_data, display_en, cursor,
        output char_clk, red, green, blue
    );
endinterface

// File: rtl/video_ula.sv
// video_ula
//
// Pixel serializer and palette stage sitting downstream of an MC6845 CRTC.
// A free-running phase counter divides the 16 MHz pixel clock into the
// character clock. Once per character the framestore byte is captured and
// then shifted out as 1/2/4-bit logical colours. Each logical colour is
// looked up in a 16-entry palette, then flash, cursor inversion and
// blanking are applied. The colour is registered once per clock.
//
// Ports:
//   pixel_clk  16 MHz master clock, all state changes on the rising edge
//   RESET      synchronous, active-high reset
//   bus        video_ula_if.slave (register writes, CRTC inputs, char_clk, RGB)
module video_ula (
    input  logic        pixel_clk,
    input  logic        RESET,
    video_ula_if.slave  bus
);

    logic [7:0] ctrl;
    logic [3:0] palette [16];
    logic [3:0] phase;
    logic [7:0] shifter;
    logic       disp_q;
    logic       cur_q;
    logic [2:0] rgb_q;

    logic [3:0] p_last;
    logic [3:0] p_half;
    logic [3:0] s_mask;
    logic [3:0] phase_inc;
    logic [3:0] pix_index;
    logic [3:0] pal_entry;
    logic       do_load;
    logic       do_shift;
    logic [2:0] colour;
    logic       unused_ctrl_bits;

    // Bits 6:5 and 1 of the control register are stored but have no effect.
    assign unused_ctrl_bits = ^{ctrl[6:5], ctrl[1]};

    // Geometry decode. Shift periods are powers of two, so "(phase+1) mod S
    // == 0" becomes a mask test. The 4-bit increment wraps at 16, which
    // every S divides, so the wrap is harmless.
    always_comb begin
        p_last    = ctrl[4] ? 4'd7 : 4'd15;
        p_half    = ctrl[4] ? 4'd4 : 4'd8;
        case (ctrl[3:2])
            2'b00:   s_mask = 4'b0111;
            2'b01:   s_mask = 4'b0011;
            2'b10:   s_mask = 4'b0001;
            default: s_mask = 4'b0000;
        endcase
        phase_inc = phase + 4'd1;
        do_load   = (phase == p_last);
        do_shift  = ((phase_inc & s_mask) == 4'd0);
    end

    // Palette lookup and colour modifiers. Inversions stack, so cursor over
    // a flashing entry cancels out. Blanking overrides everything.
    always_comb begin
        pix_index = {shifter[7], shifter[5], shifter[3], shifter[1]};
        pal_entry = palette[pix_index];
        colour    = pal_entry[2:0];
        if (pal_entry[3] && ctrl[0]) begin
            colour = ~colour;
        end
        if (cur_q) begin
            colour = ~colour;
        end
        if (!disp_q) begin
            colour = 3'b000;
        end
    end

    // Register file. Reset takes priority over a write on the same edge.
    always_ff @(posedge pixel_clk) begin
        if (RESET) begin
            ctrl <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                palette[i] <= 4'h0;
            end
        end else if (bus.wr_en) begin
            if (bus.RS) begin
                palette[bus.wr_data[7:4]] <= bus.wr_data[3:0];
            end else begin
                ctrl <= bus.wr_data;
            end
        end
    end

    // Character timing and serializer. The wrap uses >= so that a period
    // change mid-character falls straight back to phase 0. A load happens
    // only on an exact phase match, so that wrap does not capture a byte.
    always_ff @(posedge pixel_clk) begin
        if (RESET) begin
            phase   <= 4'd0;
            shifter <= 8'h00;
            disp_q  <= 1'b0;
            cur_q   <= 1'b0;
            rgb_q   <= 3'b000;
        end else begin
            phase <= (phase >= p_last) ? 4'd0 : phase_inc;
            if (do_load) begin
                shifter <= bus.vram_data;
                disp_q  <= bus.display_en;
                cur_q   <= bus.cursor & ctrl[7];
            end else if (do_shift) begin
                shifter <= {shifter[6:0], 1'b1};
            end
            rgb_q <= colour;
        end
    end

    assign bus.char_clk = (phase < p_half);
    assign bus.red      = rgb_q[0];
    assign bus.green    = rgb_q[1];
    assign bus.blue     = rgb_q[2];

endmodule

// File: tb/tb_video_ula.sv
// tb_video_ula
//
// Directed testbench for video_ula. Each scenario task drives its own
// stimulus and compares the pixel output and char_clk against
// hand-computed values. A pixel is read as {blue, green, red}.
module tb_video_ula;

    logic pixel_clk;
    logic RESET;
    int   total;
    int   bad;

    video_ula_if u_if ();

    video_ula dut (
        .pixel_clk (pixel_clk),
        .RESET     (RESET),
        .bus       (u_if.slave)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic write_reg(input logic rs, input logic [7:0] d);
        u_if.wr_en   = 1'b1;
        u_if.RS      = rs;
        u_if.wr_data = d;
        tick();
        u_if.wr_en   = 1'b0;
    endtask

    // Returns just after the edge on which char_clk rises, which is the
    // edge on which the byte is loaded.
    task automatic wait_load();
        logic prev;
        bit   found;
        prev  = u_if.char_clk;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick();
            if (u_if.char_clk && !prev) found = 1'b1;
            prev = u_if.char_clk;
        end
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_load got=no_rise want=rise");
        end
    endtask

    // Measures one low stretch and the following high stretch of char_clk.
    task automatic measure_period(output int hi, output int lo);
        hi = 0;
        lo = 0;
        for (int i = 0; i < 40 && u_if.char_clk; i++) tick();
        for (int i = 0; i < 40 && !u_if.char_clk; i++) begin
            lo++;
            tick();
        end
        for (int i = 0; i < 40 && u_if.char_clk; i++) begin
            hi++;
            tick();
        end
    endtask

    // A write presented together with reset must be ignored, so the
    // period stays at the 16-clock default.
    task automatic test_reset();
        int hi, lo;
        RESET        = 1'b1;
        u_if.wr_en   = 1'b1;
        u_if.RS      = 1'b0;
        u_if.wr_data = 8'h1C;
        tick();
        tick();
        total++;
        if ({u_if.blue, u_if.green, u_if.red} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_rgb got=%b want=000", {u_if.blue, u_if.green, u_if.red});
        end
        total++;
        if (u_if.char_clk !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_char_clk got=%b want=1", u_if.char_clk);
        end
        RESET      = 1'b0;
        u_if.wr_en = 1'b0;
        measure_period(hi, lo);
        total++;
        if (lo !== 8) begin
            bad++;
            $display("[TB] FAIL reset_low_clocks got=%0d want=8", lo);
        end
        total++;
        if (hi !== 8) begin
            bad++;
            $display("[TB] FAIL reset_high_clocks got=%0d want=8", hi);
        end
    endtask

    task automatic test_two_colour();
        logic [2:0] exp_pix [8];
        exp_pix = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b111};
        write_reg(1'b0, 8'h1C);
        for (int i = 0; i < 16; i++) begin
            write_reg(1'b1, {i[3:0], (i >= 8) ? 4'h7 : 4'h0});
        end
        u_if.display_en = 1'b1;
        u_if.cursor     = 1'b0;
        u_if.vram_data  = 8'hA5;
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== exp_pix[i]) begin
                bad++;
                $display("[TB] FAIL two_colour_pix%0d got=%b want=%b", i,
                         {u_if.blue, u_if.green, u_if.red}, exp_pix[i]);
            end
        end
    endtask

    task automatic test_blanking();
        u_if.display_en = 1'b0;
        u_if.vram_data  = 8'hA5;
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL blank_pix%0d got=%b want=000", i, {u_if.blue, u_if.green, u_if.red});
            end
        end
        u_if.display_en = 1'b1;
        u_if.vram_data  = 8'hFF;
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== 3'b111) begin
                bad++;
                $display("[TB] FAIL unblank_pix%0d got=%b want=111", i, {u_if.blue, u_if.green, u_if.red});
            end
        end
    endtask

    task automatic test_cursor();
        write_reg(1'b1, 8'hF1);
        write_reg(1'b0, 8'h9C);
        u_if.cursor    = 1'b1;
        u_if.vram_data = 8'hFF;
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== 3'b110) begin
                bad++;
                $display("[TB] FAIL cursor_pix%0d got=%b want=110", i, {u_if.blue, u_if.green, u_if.red});
            end
        end
        u_if.cursor = 1'b0;
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== 3'b001) begin
                bad++;
                $display("[TB] FAIL after_cursor_pix%0d got=%b want=001", i, {u_if.blue, u_if.green, u_if.red});
            end
        end
    endtask

    task automatic test_four_colour();
        logic [2:0] exp_pix [8];
        exp_pix = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b001, 3'b001, 3'b010, 3'b010};
        write_reg(1'b0, 8'h18);
        for (int i = 0; i < 16; i++) begin
            write_reg(1'b1, {i[3:0], (i == 15) ? 4'h1 : 4'h2});
        end
        u_if.vram_data = 8'hFF;
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== 3'b001) begin
                bad++;
                $display("[TB] FAIL four_colour_ff_pix%0d got=%b want=001", i, {u_if.blue, u_if.green, u_if.red});
            end
        end
        u_if.vram_data = 8'hAA;
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== exp_pix[i]) begin
                bad++;
                $display("[TB] FAIL four_colour_aa_pix%0d got=%b want=%b", i,
                         {u_if.blue, u_if.green, u_if.red}, exp_pix[i]);
            end
        end
    endtask

    // One pixel per character (S=8) keeps the logical index constant.
    task automatic test_flash();
        write_reg(1'b0, 8'h10);
        write_reg(1'b1, 8'h99);
        u_if.vram_data = 8'h82;
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== 3'b001) begin
                bad++;
                $display("[TB] FAIL flash_off_pix%0d got=%b want=001", i, {u_if.blue, u_if.green, u_if.red});
            end
        end
        write_reg(1'b0, 8'h11);
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== 3'b110) begin
                bad++;
                $display("[TB] FAIL flash_on_pix%0d got=%b want=110", i, {u_if.blue, u_if.green, u_if.red});
            end
        end
        u_if.vram_data = 8'h08;
        wait_load();
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({u_if.blue, u_if.green, u_if.red} !== 3'b010) begin
                bad++;
                $display("[TB] FAIL flash_noflash_pix%0d got=%b want=010", i, {u_if.blue, u_if.green, u_if.red});
            end
        end
    endtask

    task automatic test_rate_change();
        int hi, lo;
        write_reg(1'b0, 8'h00);
        for (int i = 0; i < 20; i++) tick();
        wait_load();
        for (int i = 0; i < 12; i++) tick();
        write_reg(1'b0, 8'h10);
        total++;
        if (u_if.char_clk !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rate_after_write got=%b want=0", u_if.char_clk);
        end
        tick();
        total++;
        if (u_if.char_clk !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rate_wrap got=%b want=1", u_if.char_clk);
        end
        measure_period(hi, lo);
        total++;
        if (lo !== 4) begin
            bad++;
            $display("[TB] FAIL rate_low_clocks got=%0d want=4", lo);
        end
        total++;
        if (hi !== 4) begin
            bad++;
            $display("[TB] FAIL rate_high_clocks got=%0d want=4", hi);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        RESET           = 1'b1;
        u_if.wr_en      = 1'b0;
        u_if.RS         = 1'b0;
        u_if.wr_data    = 8'h00;
        u_if.vram_data  = 8'h00;
        u_if.display_en = 1'b0;
        u_if.cursor     = 1'b0;
        $display("[TB] starting video_ula bench");
        test_reset();
        test_two_colour();
        test_blanking();
        test_cursor();
        test_four_colour();
        test_flash();
        test_rate_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
